pcie_rst_seq: RTL and testbench

PCIE_RST_SEQ -- requirements
Module: pcie_rst_seq

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pcie_rst_seq.sv | 121 ++++++++++++
 tb/tb_pcie_rst_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the PCIe reset sequencer.
package rst_seq_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        WAIT_LINK = 3'd3,
        DEBOUNCE  = 3'd4,
        RUN       = 3'd5
    } state_t;

    function automatic logic core_released(input state_t s);
        return (s == WAIT_LINK) || (s == DEBOUNCE) || (s == RUN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_rst_seq.sv
// PCIe core/user reset sequencer: PLL lock hold, link-up debounce, optional
// WAIT_LINK watchdog with retry counting (enabled by RST_SEQ_TIMEOUT_EN).
module pcie_rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               pll_locked,
    input  logic               user_lnk_up,
    output logic               core_rst_n,
    output logic               user_rst_n,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               timeout_err
);

    if (HOLD_CYCLES < 2 || DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("pcie_rst_seq: parameter out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_s;
    logic             core_q, user_q;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_hit;
`endif

    always_comb begin
        state_d = state_q;
`ifdef RST_SEQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            RESET:     state_d = WAIT_LOCK;
            WAIT_LOCK: if (lock_s) state_d = HOLD;
            HOLD:      if (cnt_q == HOLD_LAST) state_d = WAIT_LINK;
            WAIT_LINK: begin
                if (user_lnk_up) begin
                    state_d = DEBOUNCE;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = HOLD;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DEBOUNCE: begin
                if (!user_lnk_up)          state_d = WAIT_LINK;
                else if (cnt_q == DEB_LAST) state_d = RUN;
            end
            RUN:       if (!user_lnk_up) state_d = WAIT_LINK;
            default:   state_d = RESET;
        endcase
        // Loss of lock wins over every other transition once out of RESET.
        if (state_q inside {WAIT_LOCK, HOLD, WAIT_LINK, DEBOUNCE, RUN} && !lock_s) begin
            state_d = WAIT_LOCK;
`ifdef RST_SEQ_TIMEOUT_EN
            timeout_hit = 1'b0;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            core_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q  <= core_released(state_d);
            user_q  <= (state_d == RUN);
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    logic [RETRY_W-1:0] retry_q;
    logic               err_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (retry_q != '1) retry_q <= retry_q + 1'b1;
        end
    end

    assign retry_cnt   = retry_q;
    assign timeout_err = err_q;
`else
    assign retry_cnt   = '0;
    assign timeout_err = 1'b0;
`endif

    assign core_rst_n = core_q;
    assign user_rst_n = user_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Randomized bench for pcie_rst_seq against a dwell-time model of the sequencer.
module tb_pcie_rst_seq;

    localparam int H = 16;
    localparam int D = 8;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int T = 100;
`else
    localparam int T = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll = 1'b0;
    logic       lnk = 1'b0;
    logic       core, user, te;
    logic [2:0] st;
    logic [3:0] rc;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pcie_rst_seq #(
        .HOLD_CYCLES     (H),
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .pll_locked  (pll),
        .user_lnk_up (lnk),
        .core_rst_n  (core),
        .user_rst_n  (user),
        .state       (st),
        .retry_cnt   (rc),
        .timeout_err (te)
    );

    // Model: the sequencer is described by how long lock and link have been
    // continuously good, rather than by explicit states.
    bit         started;
    bit         sh0, sh1, ls, was_up;
    int         lock_age, lnk_age, wait_age, pre_lnk;
    bit         m_core, m_user, m_err;
    logic [3:0] m_retry;
    logic [2:0] m_state;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started = 0; sh0 = 0; sh1 = 0;
            lock_age = 0; lnk_age = 0; wait_age = 0;
            m_core = 0; m_user = 0; m_err = 0; m_retry = 0; m_state = 0;
        end else begin
            ls = sh1; sh1 = sh0; sh0 = pll;
            was_up = m_core; pre_lnk = lnk_age;
            if (!started) begin
                started = 1;
            end else if (!ls) begin
                lock_age = 0; lnk_age = 0; wait_age = 0;
            end else if (was_up) begin
                lnk_age = lnk ? lnk_age + 1 : 0;
                if (pre_lnk == 0 && !lnk) begin
                    wait_age++;
`ifdef RST_SEQ_TIMEOUT_EN
                    if (wait_age == T) begin
                        lock_age = 1; wait_age = 0; m_err = 1;
                        if (m_retry < 15) m_retry++;
                    end
`endif
                end else begin
                    wait_age = 0;
                end
            end else begin
                lock_age++; lnk_age = 0; wait_age = 0;
            end
            if (lnk_age > D + 1) lnk_age = D + 1;
            m_core = (lock_age >= H + 1);
            m_user = m_core && (lnk_age >= D + 1);
            if (!m_core)           m_state = (lock_age == 0) ? 3'd1 : 3'd2;
            else if (lnk_age == 0) m_state = 3'd3;
            else if (lnk_age <= D) m_state = 3'd4;
            else                   m_state = 3'd5;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (core !== m_core || user !== m_user || st !== m_state ||
                rc !== m_retry || te !== m_err) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t dut core=%b user=%b state=%0d retry=%0d err=%b want core=%b user=%b state=%0d retry=%0d err=%b",
                         $time, core, user, st, rc, te, m_core, m_user, m_state, m_retry, m_err);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Counts clock edges (first edge after the call is 1) until sel output reaches lvl.
    task automatic wait_out(input bit sel_user, input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (((sel_user ? user : core) !== lvl) && n < 300);
    endtask

    int n;

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", st, 0);
        check("rst_core", core, 0);
        check("rst_user", user, 0);
        check("rst_retry", rc, 0);
        check("rst_err", te, 0);
        rst_n = 1'b1;

        // Power-up: lock, hold, link-up, debounce.
        repeat (4) @(negedge clk);
        pll = 1'b1;
        wait_out(0, 1'b1, n);
        check("lock_to_core_edges", n, H + 3);
        @(negedge clk);
        check("wait_link_state", st, 3);
        lnk = 1'b1;
        wait_out(1, 1'b1, n);
        check("link_to_user_edges", n, D + 1);

        // One-cycle link glitch in DEBOUNCE restarts the debounce.
        @(negedge clk) lnk = 1'b0;
        @(negedge clk) lnk = 1'b1;
        repeat (3) @(negedge clk);
        lnk = 1'b0;
        @(posedge clk); #1;
        check("glitch_state", st, 3);
        check("glitch_user", user, 0);
        @(negedge clk) lnk = 1'b1;
        wait_out(1, 1'b1, n);
        check("debounce_restart_edges", n, D + 1);

        // Lock lost for 3 cycles in RUN.
        @(negedge clk) pll = 1'b0;
        wait_out(0, 1'b0, n);
        check("lock_drop_edges", n, 3);
        check("lock_drop_user", user, 0);
        @(negedge clk) pll = 1'b1;
        wait_out(0, 1'b1, n);
        check("relock_core_edges", n, H + 3);
        wait_out(1, 1'b1, n);
        check("relock_user_edges", n, D + 1);

        // Asynchronous reset in RUN, mid-cycle.
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_core", core, 0);
        check("async_user", user, 0);
        check("async_state", st, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pll) begin if ($urandom_range(0, 299) == 0) pll = 1'b0; end
            else     begin if ($urandom_range(0, 2) == 0)   pll = 1'b1; end
            if (lnk) begin if ($urandom_range(0, 59) == 0) lnk = 1'b0; end
            else     begin if ($urandom_range(0, 7) == 0)  lnk = 1'b1; end
            if ($urandom_range(0, 999) == 0) begin
                @(posedge clk); #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk) rst_n = 1'b1;
            end
        end

`ifdef RST_SEQ_TIMEOUT_EN
        @(negedge clk);
        pll = 1'b1; lnk = 1'b0;
        repeat (16 * (T + H) + 200) @(negedge clk);
        check("timeout_retry_sat", rc, 15);
        check("timeout_err_sticky", te, 1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
